// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter states and PC step.
package branch_predictor_pkg;
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_t;

  localparam int BP_PC_STEP = 4;
endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t i_cur,
  input  logic    i_taken,
  output bp_ctr_t o_next
);
  always_comb begin
    o_next = i_cur;
    if (i_taken) begin
      if (i_cur != STRONG_T) o_next = bp_ctr_t'(i_cur + 2'd1);
    end else begin
      if (i_cur != STRONG_NT) o_next = bp_ctr_t'(i_cur - 2'd1);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit counter BHT plus direct-mapped BTB, with
// combinational lookup at IF and resolution/training at ID.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  id_is_branch,
  input  logic                  id_stall,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic                  id_taken,
  input  logic [DATA_WIDTH-1:0] id_target,
  input  logic                  id_pred_taken,
  input  logic [DATA_WIDTH-1:0] id_pred_target,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  logic                  r_valid  [ENTRIES];
  bp_ctr_t               r_ctr    [ENTRIES];
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [DATA_WIDTH-1:0] r_target [ENTRIES];
  logic [31:0]           r_perf_br;
  logic [31:0]           r_perf_mis;

  logic [IDX_W-1:0]      w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic [IDX_W-1:0]      w_id_idx;
  logic [TAG_W-1:0]      w_id_tag;
  logic                  w_id_hit;
  logic                  w_active;
  logic [DATA_WIDTH-1:0] w_id_pc_next;
  bp_ctr_t               w_ctr_next;
  logic                  w_unused;

  assign w_unused = ^{if_pc[1:0], id_pc[1:0]};

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[DATA_WIDTH-1:IDX_W+2];
  assign w_id_idx = id_pc[IDX_W+1:2];
  assign w_id_tag = id_pc[DATA_WIDTH-1:IDX_W+2];

  // Lookup reads the registered tables, so same-cycle updates are not seen.
  assign pred_taken  = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag) && r_ctr[w_if_idx][1];
  assign pred_target = r_target[w_if_idx];

  assign w_id_hit     = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);
  assign w_active     = !id_stall && (id_is_branch || id_pred_taken);
  assign w_id_pc_next = id_pc + DATA_WIDTH'(BP_PC_STEP);

  bp_sat_counter u_sat_counter (
    .i_cur   (r_ctr[w_id_idx]),
    .i_taken (id_taken),
    .o_next  (w_ctr_next)
  );

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = w_id_pc_next;
    if (w_active) begin
      if (id_is_branch) begin
        if (id_taken && (!id_pred_taken || (id_pred_target != id_target))) begin
          redirect    = 1'b1;
          redirect_pc = id_target;
        end else if (!id_taken && id_pred_taken) begin
          redirect    = 1'b1;
        end
      end else begin
        // A predicted-taken non-branch is an alias: fall through to id_pc+4.
        redirect = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= WEAK_NT;
      end
      r_perf_br  <= '0;
      r_perf_mis <= '0;
    end else begin
      if (w_active) begin
        if (id_is_branch) begin
          if (w_id_hit) begin
            r_ctr[w_id_idx] <= w_ctr_next;
          end else if (id_taken) begin
            r_valid[w_id_idx] <= 1'b1;
            r_ctr[w_id_idx]   <= WEAK_T;
          end
        end else begin
          r_valid[w_id_idx] <= 1'b0;
        end
      end
      if (w_active && id_is_branch && (r_perf_br != 32'hFFFF_FFFF))
        r_perf_br <= r_perf_br + 32'd1;
      if (redirect && (r_perf_mis != 32'hFFFF_FFFF))
        r_perf_mis <= r_perf_mis + 32'd1;
    end
  end

  // Tag/target payload is gated by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_active && id_is_branch && id_taken) begin
      r_target[w_id_idx] <= id_target;
      r_tag[w_id_idx]    <= w_id_tag;
    end
  end

  assign perf_branches    = r_perf_br;
  assign perf_mispredicts = r_perf_mis;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic against a table-level reference model.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_is_branch = 1'b0;
  logic        id_stall = 1'b0;
  logic [31:0] id_pc = '0;
  logic        id_taken = 1'b0;
  logic [31:0] id_target = '0;
  logic        id_pred_taken = 1'b0;
  logic [31:0] id_pred_target = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16)) dut (
    .clk(clk), .rstN(rstN), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .id_is_branch(id_is_branch), .id_stall(id_stall), .id_pc(id_pc), .id_taken(id_taken),
    .id_target(id_target), .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  // Reference model: entry index = (pc/4) mod 16, tag = pc/64, counter as integer 0..3.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_br;
  int          m_mis;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_ctr[i] = 1; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_br = 0; m_mis = 0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int idx = int'((pc / 4) % 16);
    return m_valid[idx] && (m_tag[idx] == pc / 64);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int idx = int'((pc / 4) % 16);
    t   = m_hit(pc) && (m_ctr[idx] >= 2);
    tgt = m_tgt[idx];
  endfunction

  function automatic void m_resolve(input bit stall, input bit br, input logic [31:0] pc,
                                    input bit tk, input logic [31:0] tgt, input bit pt,
                                    input logic [31:0] ptg, output bit rd, output logic [31:0] rpc);
    rd = 0; rpc = pc + 32'd4;
    if (stall || !(br || pt)) return;
    if (!br) begin rd = 1; rpc = pc + 32'd4; end
    else if (!pt && tk) begin rd = 1; rpc = tgt; end
    else if (pt && !tk) begin rd = 1; rpc = pc + 32'd4; end
    else if (pt && tk && ptg != tgt) begin rd = 1; rpc = tgt; end
  endfunction

  function automatic void m_update(input bit stall, input bit br, input logic [31:0] pc,
                                   input bit tk, input logic [31:0] tgt, input bit rd);
    int idx = int'((pc / 4) % 16);
    if (stall || !(br || (rd && !br))) return;
    if (br) begin
      m_br++;
      if (m_hit(pc)) begin
        m_ctr[idx] = tk ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3) : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        if (tk) m_tgt[idx] = tgt;
      end else if (tk) begin
        m_valid[idx] = 1; m_tag[idx] = pc / 64; m_tgt[idx] = tgt; m_ctr[idx] = 2;
      end
    end else begin
      m_valid[idx] = 0;
    end
    if (rd) m_mis++;
  endfunction

  task automatic set_idle();
    id_is_branch = 0; id_stall = 0; id_pc = '0; id_taken = 0;
    id_target = '0; id_pred_taken = 0; id_pred_target = '0;
  endtask

  task automatic set_id(input bit br, input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                        input bit pt, input logic [31:0] ptg);
    id_is_branch = br; id_stall = 0; id_pc = pc; id_taken = tk;
    id_target = tgt; id_pred_taken = pt; id_pred_target = ptg;
  endtask

  task automatic test_reset();
    set_idle(); if_pc = 32'h100; rstN = 0;
    #12;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got=%b exp=0", pred_taken); end
    n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    n_cmp++; if (perf_branches !== 32'd0) begin n_fail++; $display("FAIL reset_perf_br got=%0d exp=0", perf_branches); end
    n_cmp++; if (perf_mispredicts !== 32'd0) begin n_fail++; $display("FAIL reset_perf_mis got=%0d exp=0", perf_mispredicts); end
    @(negedge clk); rstN = 1;
  endtask

  task automatic test_allocate();
    @(negedge clk); if_pc = 32'h100; set_id(1, 32'h100, 1, 32'h80, 0, 32'h0); #1;
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL alloc_redirect got=%b exp=1", redirect); end
    n_cmp++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL alloc_rpc got=%h exp=80", redirect_pc); end
    @(negedge clk); set_idle(); if_pc = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_pred got=%b exp=1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h80) begin n_fail++; $display("FAIL alloc_target got=%h exp=80", pred_target); end
    n_cmp++; if (perf_branches !== 32'd1) begin n_fail++; $display("FAIL alloc_perf_br got=%0d exp=1", perf_branches); end
    n_cmp++; if (perf_mispredicts !== 32'd1) begin n_fail++; $display("FAIL alloc_perf_mis got=%0d exp=1", perf_mispredicts); end
  endtask

  task automatic test_train_down();
    @(negedge clk); set_id(1, 32'h100, 0, 32'h80, 1, 32'h80); #1;
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL nt1_redirect got=%b exp=1", redirect); end
    n_cmp++; if (redirect_pc !== 32'h104) begin n_fail++; $display("FAIL nt1_rpc got=%h exp=104", redirect_pc); end
    @(negedge clk); set_idle(); if_pc = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt1_pred got=%b exp=0", pred_taken); end
    @(negedge clk); set_id(1, 32'h100, 0, 32'h80, 0, 32'h0); #1;
    n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL nt2_redirect got=%b exp=0", redirect); end
    @(negedge clk); set_id(1, 32'h100, 0, 32'h80, 0, 32'h0); #1;
    n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL nt3_redirect got=%b exp=0", redirect); end
    // Counter must sit at 00; one taken lifts it only to 01 (still predicts not-taken).
    @(negedge clk); set_id(1, 32'h100, 1, 32'h80, 0, 32'h0);
    @(negedge clk); set_idle(); if_pc = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_low_pred got=%b exp=0", pred_taken); end
    @(negedge clk); set_id(1, 32'h100, 1, 32'h80, 0, 32'h0);
    @(negedge clk); set_idle(); if_pc = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL retrain_pred got=%b exp=1", pred_taken); end
    n_cmp++; if (perf_branches !== 32'd6) begin n_fail++; $display("FAIL train_perf_br got=%0d exp=6", perf_branches); end
    n_cmp++; if (perf_mispredicts !== 32'd4) begin n_fail++; $display("FAIL train_perf_mis got=%0d exp=4", perf_mispredicts); end
  endtask

  task automatic test_target_mismatch();
    @(negedge clk); if_pc = 32'h100; set_id(1, 32'h100, 1, 32'hC0, 1, 32'h80); #1;
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL tmis_redirect got=%b exp=1", redirect); end
    n_cmp++; if (redirect_pc !== 32'hC0) begin n_fail++; $display("FAIL tmis_rpc got=%h exp=c0", redirect_pc); end
    @(negedge clk); set_idle(); if_pc = 32'h100; #1;
    n_cmp++; if (pred_target !== 32'hC0) begin n_fail++; $display("FAIL tmis_target got=%h exp=c0", pred_target); end
  endtask

  task automatic test_alias();
    @(negedge clk); if_pc = 32'h100; set_id(0, 32'h140, 0, 32'h0, 1, 32'hC0); #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_sameidx_old got=%b exp=1", pred_taken); end
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL alias_redirect got=%b exp=1", redirect); end
    n_cmp++; if (redirect_pc !== 32'h144) begin n_fail++; $display("FAIL alias_rpc got=%h exp=144", redirect_pc); end
    @(negedge clk); set_idle(); if_pc = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_pred got=%b exp=0", pred_taken); end
    n_cmp++; if (perf_mispredicts !== 32'd6) begin n_fail++; $display("FAIL alias_perf_mis got=%0d exp=6", perf_mispredicts); end
  endtask

  task automatic test_stall();
    @(negedge clk); set_id(1, 32'h100, 1, 32'h300, 0, 32'h0); id_stall = 1; #1;
    n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL stall_redirect got=%b exp=0", redirect); end
    @(negedge clk); set_idle(); if_pc = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL stall_pred got=%b exp=0", pred_taken); end
    n_cmp++; if (perf_branches !== 32'd7) begin n_fail++; $display("FAIL stall_perf_br got=%0d exp=7", perf_branches); end
    n_cmp++; if (perf_mispredicts !== 32'd6) begin n_fail++; $display("FAIL stall_perf_mis got=%0d exp=6", perf_mispredicts); end
  endtask

  task automatic test_wrap();
    @(negedge clk); set_id(0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h40); #1;
    n_cmp++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_rpc got=%h exp=0", redirect_pc); end
    @(negedge clk); set_idle();
  endtask

  task automatic test_midreset();
    @(negedge clk); set_id(1, 32'h100, 1, 32'h90, 0, 32'h0);
    @(negedge clk); set_idle(); if_pc = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL mrst_pre_pred got=%b exp=1", pred_taken); end
    set_id(1, 32'h104, 1, 32'hA0, 0, 32'h0); #1;
    rstN = 0; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL mrst_async_pred got=%b exp=0", pred_taken); end
    n_cmp++; if (perf_branches !== 32'd0) begin n_fail++; $display("FAIL mrst_perf_br got=%0d exp=0", perf_branches); end
    set_idle(); #1;
    n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL mrst_redirect got=%b exp=0", redirect); end
    @(negedge clk); rstN = 1; if_pc = 32'h104; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL mrst_discard_pred got=%b exp=0", pred_taken); end
    n_cmp++; if (perf_mispredicts !== 32'd0) begin n_fail++; $display("FAIL mrst_perf_mis got=%0d exp=0", perf_mispredicts); end
    m_reset();
  endtask

  task automatic test_random();
    bit          et, rd, br, st, tk, pt;
    logic [31:0] etg, rpc, pc, tgt, ptg;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if_pc = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      pc    = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
      br    = ($urandom_range(0, 3) != 0);
      st    = ($urandom_range(0, 7) == 0);
      tk    = $urandom_range(0, 1);
      tgt   = 32'($urandom_range(0, 7)) << 4;
      m_lookup(pc, pt, ptg);
      if ($urandom_range(0, 3) == 0) pt = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) ptg = tgt;
      set_id(br, pc, tk, tgt, pt, ptg); id_stall = st;
      #1;
      m_lookup(if_pc, et, etg);
      m_resolve(st, br, pc, tk, tgt, pt, ptg, rd, rpc);
      n_cmp++; if (pred_taken !== et) begin n_fail++; $display("FAIL rnd_pred n=%0d got=%b exp=%b", n, pred_taken, et); end
      if (et) begin
        n_cmp++; if (pred_target !== etg) begin n_fail++; $display("FAIL rnd_target n=%0d got=%h exp=%h", n, pred_target, etg); end
      end
      n_cmp++; if (redirect !== rd) begin n_fail++; $display("FAIL rnd_redirect n=%0d got=%b exp=%b", n, redirect, rd); end
      if (rd) begin
        n_cmp++; if (redirect_pc !== rpc) begin n_fail++; $display("FAIL rnd_rpc n=%0d got=%h exp=%h", n, redirect_pc, rpc); end
      end
      m_update(st, br, pc, tk, tgt, rd);
      @(posedge clk); #1;
      n_cmp++; if (perf_branches !== 32'(m_br)) begin n_fail++; $display("FAIL rnd_perf_br n=%0d got=%0d exp=%0d", n, perf_branches, m_br); end
      n_cmp++; if (perf_mispredicts !== 32'(m_mis)) begin n_fail++; $display("FAIL rnd_perf_mis n=%0d got=%0d exp=%0d", n, perf_mispredicts, m_mis); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_allocate();
    test_train_down();
    test_target_mismatch();
    test_alias();
    test_stall();
    test_wrap();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
